// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the ARM control unit: condition codes, opcode classes,
// data-processing commands and datapath select values.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
        MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
        HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
        GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
    } cond_e;

    typedef enum logic [1:0] {
        OP_DP  = 2'b00,
        OP_MEM = 2'b01,
        OP_BR  = 2'b10,
        OP_UND = 2'b11
    } op_e;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    localparam logic [1:0] REGSRC_DP  = 2'b00;
    localparam logic [1:0] REGSRC_BR  = 2'b01;
    localparam logic [1:0] REGSRC_STR = 2'b10;

endpackage

// File: rtl/arm_cond_logic.sv
// NZCV flags register, condition evaluation and gating of the architectural
// side effects (register write, memory write, PC load, flag update).
module arm_cond_logic
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  cond_e      cond_i,
    input  logic [3:0] alu_flags_i,
    input  logic [1:0] flag_w_i,
    input  logic       pcs_i,
    input  logic       reg_w_i,
    input  logic       mem_w_i,
    input  logic       no_write_i,
    input  logic       undef_i,
    output logic [3:0] flags_o,
    output logic       reg_write_o,
    output logic       mem_write_o,
    output logic       pc_src_o
);

    logic [3:0] flags_q, flags_d;
    logic       n, z, c, v;
    logic       cond_ex;
    logic       exec;

    assign {n, z, c, v} = flags_q;

    always_comb begin
        cond_ex = 1'b0;
        case (cond_i)
            EQ: cond_ex = z;
            NE: cond_ex = ~z;
            CS: cond_ex = c;
            CC: cond_ex = ~c;
            MI: cond_ex = n;
            PL: cond_ex = ~n;
            VS: cond_ex = v;
            VC: cond_ex = ~v;
            HI: cond_ex = c & ~z;
            LS: cond_ex = ~c | z;
            GE: cond_ex = (n == v);
            LT: cond_ex = (n != v);
            GT: cond_ex = ~z & (n == v);
            LE: cond_ex = z | (n != v);
            AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // An undefined encoding must not leave any architectural trace.
    assign exec = cond_ex & ~undef_i;

    assign reg_write_o = reg_w_i & exec & ~no_write_i;
    assign mem_write_o = mem_w_i & exec;
    assign pc_src_o    = pcs_i & exec;

    always_comb begin
        flags_d = flags_q;
        if (flag_w_i[1] && exec) flags_d[3:2] = alu_flags_i[3:2];
        if (flag_w_i[0] && exec) flags_d[1:0] = alu_flags_i[1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) flags_q <= 4'b0000;
        else       flags_q <= flags_d;
    end

    assign flags_o = flags_q;

endmodule

// File: rtl/arm_control_unit.sv
// Single-cycle ARM control unit: main/ALU decode feeding the conditional
// execution block, plus the undefined-instruction indicator.
module arm_control_unit
    import arm_ctrl_pkg::*;
#(
    parameter bit UNDEF_STICKY = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic [1:0]  RegSrc,
    output logic        RegWrite,
    output logic [1:0]  ImmSrc,
    output logic        ALUSrc,
    output logic [1:0]  ALUControl,
    output logic        MemtoReg,
    output logic        PCSrc,
    output logic        MemWrite,
    output logic [3:0]  Flags,
    output logic        Undef
);

    cond_e      cond;
    op_e        op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic [3:0] rd;
    logic       s_bit;
    logic       reg_w, mem_w, br, no_write, pcs, undef_dec;
    logic [1:0] flag_w;
    logic       undef_q, undef_d;
    logic       unused_instr;

    assign cond  = cond_e'(Instr[31:28]);
    assign op    = op_e'(Instr[27:26]);
    assign funct = Instr[25:20];
    assign cmd   = funct[4:1];
    assign s_bit = funct[0];
    assign rd    = Instr[15:12];
    assign unused_instr = ^{Instr[19:16], Instr[11:0]};

    always_comb begin
        RegSrc     = REGSRC_DP;
        ImmSrc     = IMM_DP;
        ALUSrc     = 1'b0;
        ALUControl = ALU_ADD;
        MemtoReg   = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        br         = 1'b0;
        no_write   = 1'b0;
        flag_w     = 2'b00;
        undef_dec  = (cond == NV);
        case (op)
            OP_DP: begin
                ALUSrc = funct[5];
                reg_w  = 1'b1;
                case (cmd)
                    CMD_ADD: ALUControl = ALU_ADD;
                    CMD_SUB: ALUControl = ALU_SUB;
                    CMD_AND: ALUControl = ALU_AND;
                    CMD_ORR: ALUControl = ALU_ORR;
                    CMD_CMP: begin
                        ALUControl = ALU_SUB;
                        no_write   = 1'b1;
                        if (!s_bit) undef_dec = 1'b1;
                    end
                    default: undef_dec = 1'b1;
                endcase
                flag_w[1] = s_bit;
                flag_w[0] = s_bit & ((cmd == CMD_ADD) | (cmd == CMD_SUB) | (cmd == CMD_CMP));
            end
            OP_MEM: begin
                RegSrc   = s_bit ? REGSRC_DP : REGSRC_STR;
                ImmSrc   = IMM_MEM;
                ALUSrc   = 1'b1;
                MemtoReg = s_bit;
                reg_w    = s_bit;
                mem_w    = ~s_bit;
            end
            OP_BR: begin
                RegSrc = REGSRC_BR;
                ImmSrc = IMM_BR;
                ALUSrc = 1'b1;
                br     = 1'b1;
            end
            default: undef_dec = 1'b1;
        endcase
        // Undefined encodings present an all-zero select bundle downstream.
        if (undef_dec) begin
            RegSrc     = REGSRC_DP;
            ImmSrc     = IMM_DP;
            ALUSrc     = 1'b0;
            ALUControl = ALU_ADD;
            MemtoReg   = 1'b0;
        end
    end

    assign pcs = br | ((rd == 4'hF) & reg_w);

    arm_cond_logic u_cond (
        .clk         (clk),
        .reset       (reset),
        .cond_i      (cond),
        .alu_flags_i (ALUFlags),
        .flag_w_i    (flag_w),
        .pcs_i       (pcs),
        .reg_w_i     (reg_w),
        .mem_w_i     (mem_w),
        .no_write_i  (no_write),
        .undef_i     (undef_dec),
        .flags_o     (Flags),
        .reg_write_o (RegWrite),
        .mem_write_o (MemWrite),
        .pc_src_o    (PCSrc)
    );

    assign undef_d = undef_dec | (UNDEF_STICKY & undef_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) undef_q <= 1'b0;
        else       undef_q <= undef_d;
    end

    assign Undef = UNDEF_STICKY ? undef_q : undef_dec;

endmodule

// File: tb/tb_arm_control_unit.sv
// Directed bench for arm_control_unit: hand-computed decode and flag vectors.
module tb_arm_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic [1:0]  RegSrc;
    logic        RegWrite;
    logic [1:0]  ImmSrc;
    logic        ALUSrc;
    logic [1:0]  ALUControl;
    logic        MemtoReg;
    logic        PCSrc;
    logic        MemWrite;
    logic [3:0]  Flags;
    logic        Undef;

    int n_cmp = 0;
    int n_err = 0;

    arm_control_unit dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .RegSrc     (RegSrc),
        .RegWrite   (RegWrite),
        .ImmSrc     (ImmSrc),
        .ALUSrc     (ALUSrc),
        .ALUControl (ALUControl),
        .MemtoReg   (MemtoReg),
        .PCSrc      (PCSrc),
        .MemWrite   (MemWrite),
        .Flags      (Flags),
        .Undef      (Undef)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive one instruction shortly after the active edge, let it settle.
    task automatic apply(input logic [31:0] instr, input logic [3:0] aluf);
        Instr    = instr;
        ALUFlags = aluf;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        Instr    = 32'hE280_002A;
        ALUFlags = 4'b0000;
        #3;
        check("reset_flags", Flags, 4'b0000);
        check("reset_undef", {3'b0, Undef}, 4'b0000);
        #9 reset = 1'b0;
        tick();

        // ADD R0,R0,#42 with no S: flags must stay put
        apply(32'hE280_002A, 4'b1111);
        check("add_regsrc", {2'b0, RegSrc}, 4'b0000);
        check("add_regwrite", {3'b0, RegWrite}, 4'b0001);
        check("add_immsrc", {2'b0, ImmSrc}, 4'b0000);
        check("add_alusrc", {3'b0, ALUSrc}, 4'b0001);
        check("add_aluctl", {2'b0, ALUControl}, 4'b0000);
        check("add_memtoreg", {3'b0, MemtoReg}, 4'b0000);
        check("add_pcsrc", {3'b0, PCSrc}, 4'b0000);
        check("add_memwrite", {3'b0, MemWrite}, 4'b0000);
        tick();
        check("add_flags", Flags, 4'b0000);

        // CMP R0,#42 sets Z
        apply(32'hE350_002A, 4'b0100);
        check("cmp_regwrite", {3'b0, RegWrite}, 4'b0000);
        check("cmp_aluctl", {2'b0, ALUControl}, 4'b0001);
        check("cmp_flags_old", Flags, 4'b0000);
        tick();
        check("cmp_flags_new", Flags, 4'b0100);

        apply(32'h0A00_0002, 4'b0000);
        check("beq_pcsrc", {3'b0, PCSrc}, 4'b0001);
        check("beq_regsrc", {2'b0, RegSrc}, 4'b0001);
        check("beq_immsrc", {2'b0, ImmSrc}, 4'b0010);
        check("beq_regwrite", {3'b0, RegWrite}, 4'b0000);
        tick();

        apply(32'h1A00_0002, 4'b0000);
        check("bne_pcsrc", {3'b0, PCSrc}, 4'b0000);
        tick();

        // ADDNES with Z=1 is skipped, flags untouched
        apply(32'h1291_1001, 4'b1010);
        check("addnes_regwrite", {3'b0, RegWrite}, 4'b0000);
        tick();
        check("addnes_flags", Flags, 4'b0100);

        apply(32'hE291_1001, 4'b1010);
        check("adds_regwrite", {3'b0, RegWrite}, 4'b0001);
        tick();
        check("adds_flags", Flags, 4'b1010);

        // Other ALU commands and register operand form
        apply(32'hE240_0001, 4'b0000);
        check("sub_aluctl", {2'b0, ALUControl}, 4'b0001);
        apply(32'hE200_0001, 4'b0000);
        check("and_aluctl", {2'b0, ALUControl}, 4'b0010);
        apply(32'hE380_0001, 4'b0000);
        check("orr_aluctl", {2'b0, ALUControl}, 4'b0011);
        apply(32'hE080_0001, 4'b0000);
        check("addreg_alusrc", {3'b0, ALUSrc}, 4'b0000);
        tick();

        apply(32'hE580_1004, 4'b0000);
        check("str_regsrc", {2'b0, RegSrc}, 4'b0010);
        check("str_immsrc", {2'b0, ImmSrc}, 4'b0001);
        check("str_alusrc", {3'b0, ALUSrc}, 4'b0001);
        check("str_memwrite", {3'b0, MemWrite}, 4'b0001);
        check("str_regwrite", {3'b0, RegWrite}, 4'b0000);
        check("str_aluctl", {2'b0, ALUControl}, 4'b0000);
        tick();

        apply(32'hE590_1004, 4'b0000);
        check("ldr_memtoreg", {3'b0, MemtoReg}, 4'b0001);
        check("ldr_regwrite", {3'b0, RegWrite}, 4'b0001);
        check("ldr_memwrite", {3'b0, MemWrite}, 4'b0000);
        check("ldr_regsrc", {2'b0, RegSrc}, 4'b0000);
        tick();
        check("mem_flags", Flags, 4'b1010);

        apply(32'hE280_F008, 4'b0000);
        check("addpc_pcsrc", {3'b0, PCSrc}, 4'b0001);
        check("addpc_regwrite", {3'b0, RegWrite}, 4'b0001);
        tick();

        // Re-establish Z=1, then ADDNE R15 must be suppressed
        apply(32'hE350_002A, 4'b0100);
        tick();
        check("cmp2_flags", Flags, 4'b0100);
        apply(32'h1280_F008, 4'b0000);
        check("addnepc_pcsrc", {3'b0, PCSrc}, 4'b0000);
        check("addnepc_regwrite", {3'b0, RegWrite}, 4'b0000);
        tick();

        // Undefined op class
        apply(32'hEC00_0000, 4'b1111);
        check("und_regwrite", {3'b0, RegWrite}, 4'b0000);
        check("und_memwrite", {3'b0, MemWrite}, 4'b0000);
        check("und_pcsrc", {3'b0, PCSrc}, 4'b0000);
        check("und_undef_before", {3'b0, Undef}, 4'b0000);
        tick();
        check("und_undef_set", {3'b0, Undef}, 4'b0001);
        check("und_flags", Flags, 4'b0100);
        apply(32'hE280_002A, 4'b0000);
        tick();
        check("und_undef_held", {3'b0, Undef}, 4'b0001);

        // Asynchronous reset between edges
        #2 reset = 1'b1;
        #1;
        check("areset_flags", Flags, 4'b0000);
        check("areset_undef", {3'b0, Undef}, 4'b0000);
        #1 reset = 1'b0;
        tick();

        apply(32'h0A00_0002, 4'b0000);
        check("post_reset_beq", {3'b0, PCSrc}, 4'b0000);
        tick();

        // CMP without S: undefined, selects zeroed, nothing written
        apply(32'hE340_002A, 4'b0100);
        check("cmpnos_aluctl", {2'b0, ALUControl}, 4'b0000);
        check("cmpnos_alusrc", {3'b0, ALUSrc}, 4'b0000);
        tick();
        check("cmpnos_flags", Flags, 4'b0000);
        check("cmpnos_undef", {3'b0, Undef}, 4'b0001);

        // Cond = 1111 is undefined and never executes
        #2 reset = 1'b1;
        #1 reset = 1'b0;
        tick();
        apply(32'hF291_F001, 4'b1111);
        check("nv_regwrite", {3'b0, RegWrite}, 4'b0000);
        check("nv_pcsrc", {3'b0, PCSrc}, 4'b0000);
        tick();
        check("nv_flags", Flags, 4'b0000);
        check("nv_undef", {3'b0, Undef}, 4'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
